// File: rtl/div_square_pkg.sv
// Shared types and constants for the divide-then-square datapath.
package div_square_pkg;
  localparam int Y_W       = 16;
  localparam int A_W       = 8;
  localparam int DIV_ITERS = 16;
  localparam int SQR_ITERS = 8;
  localparam logic [Y_W-1:0] ERR_RESULT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    SQR  = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/div_square_system_if.sv
// Start/busy handshake bundle for div_square_system.
interface div_square_system_if;
  import div_square_pkg::*;
  logic           start_i;
  logic [Y_W-1:0] y_bi;
  logic [A_W-1:0] a_bi;
  logic [Y_W-1:0] result_bo;
  logic           err_o;
  logic           busy_o;
  logic           done_o;

  modport master (output start_i, y_bi, a_bi,
                  input  result_bo, err_o, busy_o, done_o);
  modport slave  (input  start_i, y_bi, a_bi,
                  output result_bo, err_o, busy_o, done_o);
endinterface

// File: rtl/div_square_system_div_seq.sv
// 16/8 restoring divider, one quotient bit per edge MSB first; the full
// 16-bit quotient is kept so the caller can detect overflow past 8 bits.
module div_seq
  import div_square_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic [Y_W-1:0] y_bi,
  input  logic [A_W-1:0] a_bi,
  output logic           busy_o,
  output logic           last_o,
  output logic [Y_W-1:0] quot_bo
);
  logic [Y_W-1:0] dvd, quot, quot_nxt;
  logic [A_W-1:0] dvs;
  logic [A_W:0]   rem, shifted, rem_nxt;
  logic [3:0]     cnt;
  logic           ge;

  always_comb begin
    shifted  = {rem[A_W-1:0], dvd[Y_W-1]};
    ge       = shifted >= {1'b0, dvs};
    rem_nxt  = ge ? shifted - {1'b0, dvs} : shifted;
    quot_nxt = {quot[Y_W-2:0], ge};
  end

  // quot_bo already includes this edge's bit so the final edge can be acted on
  assign last_o  = busy_o && (cnt == 4'(DIV_ITERS - 1));
  assign quot_bo = quot_nxt;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      quot   <= '0;
      cnt    <= '0;
      busy_o <= 1'b0;
    end else if (start_i && !busy_o) begin
      dvd    <= y_bi;
      dvs    <= a_bi;
      rem    <= '0;
      quot   <= '0;
      cnt    <= '0;
      busy_o <= 1'b1;
    end else if (busy_o) begin
      dvd  <= {dvd[Y_W-2:0], 1'b0};
      rem  <= rem_nxt;
      quot <= quot_nxt;
      cnt  <= cnt + 4'd1;
      if (last_o) busy_o <= 1'b0;
    end
  end
endmodule

// File: rtl/div_square_system.sv
// Recovers b = floor(y/a)^2: sequential divide, then shift-add square.
module div_square_system
  import div_square_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  div_square_system_if.slave bus
);
  state_t         state;
  logic [Y_W-1:0] result;
  logic           err;
  logic [Y_W-1:0] sq_acc, sq_mcand, sq_acc_nxt;
  logic [A_W-1:0] sq_mplier;
  logic [2:0]     sq_cnt;
  logic           div_start, div_busy, div_last;
  logic [Y_W-1:0] div_quot;

  assign div_start = (state == IDLE) && bus.start_i && (bus.a_bi != '0);

  div_seq u_div (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (div_start),
    .y_bi    (bus.y_bi),
    .a_bi    (bus.a_bi),
    .busy_o  (div_busy),
    .last_o  (div_last),
    .quot_bo (div_quot)
  );

  assign sq_acc_nxt = sq_acc + (sq_mplier[0] ? sq_mcand : '0);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      result    <= '0;
      err       <= 1'b0;
      sq_acc    <= '0;
      sq_mcand  <= '0;
      sq_mplier <= '0;
      sq_cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start_i) begin
          err <= 1'b0;
          if (bus.a_bi == '0) begin
            err    <= 1'b1;
            result <= ERR_RESULT;
            state  <= DONE;
          end else begin
            state <= DIV;
          end
        end
        DIV: if (div_busy && div_last) begin
          // quotient no longer fits the squarer's 8-bit operand
          if (|div_quot[Y_W-1:A_W]) begin
            err    <= 1'b1;
            result <= ERR_RESULT;
            state  <= DONE;
          end else begin
            sq_acc    <= '0;
            sq_mcand  <= {{(Y_W-A_W){1'b0}}, div_quot[A_W-1:0]};
            sq_mplier <= div_quot[A_W-1:0];
            sq_cnt    <= '0;
            state     <= SQR;
          end
        end
        SQR: begin
          sq_acc    <= sq_acc_nxt;
          sq_mcand  <= {sq_mcand[Y_W-2:0], 1'b0};
          sq_mplier <= {1'b0, sq_mplier[A_W-1:1]};
          sq_cnt    <= sq_cnt + 3'd1;
          if (sq_cnt == 3'(SQR_ITERS - 1)) begin
            result <= sq_acc_nxt;
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy_o    = (state != IDLE);
  assign bus.done_o    = (state == DONE);
  assign bus.result_bo = result;
  assign bus.err_o     = err;
endmodule

// File: tb/tb_div_square_system.sv
// Randomized and directed checks of div_square_system against an arithmetic model.
module tb_div_square_system;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  div_square_system_if bus ();

  div_square_system dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: floor division then square; error paths with their latencies.
  task automatic model(input logic [15:0] y, input logic [7:0] a,
                       output logic [15:0] res, output logic err, output int lat);
    int q;
    if (a == 0) begin
      res = 16'hFFFF; err = 1'b1; lat = 0;
    end else begin
      q = int'(y) / int'(a);
      if (q > 255) begin
        res = 16'hFFFF; err = 1'b1; lat = 16;
      end else begin
        res = 16'(q * q); err = 1'b0; lat = 24;
      end
    end
  endtask

  // Called at a negedge; returns at the negedge after the done cycle.
  task automatic run_op(input string tag, input logic [15:0] y, input logic [7:0] a);
    logic [15:0] exp_res;
    logic        exp_err;
    int          exp_lat, lat;
    bit          busy_ok;
    model(y, a, exp_res, exp_err, exp_lat);
    bus.y_bi = y; bus.a_bi = a; bus.start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.y_bi = 16'($urandom);
    bus.a_bi = 8'($urandom);
    lat = 0; busy_ok = 1'b1;
    while (!bus.done_o && lat < 40) begin
      if (!bus.busy_o) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    n_vec++;
    if (lat !== exp_lat) begin
      n_bad++;
      $display("FAIL %s latency y=%0d a=%0d got %0d want %0d", tag, y, a, lat, exp_lat);
    end
    n_vec++;
    if (!busy_ok || bus.busy_o !== 1'b1) begin
      n_bad++;
      $display("FAIL %s busy dropped during op y=%0d a=%0d", tag, y, a);
    end
    n_vec++;
    if (bus.result_bo !== exp_res || bus.err_o !== exp_err) begin
      n_bad++;
      $display("FAIL %s result y=%0d a=%0d got %0d/%0b want %0d/%0b",
               tag, y, a, bus.result_bo, bus.err_o, exp_res, exp_err);
    end
    @(negedge clk);
    n_vec++;
    if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.result_bo !== exp_res) begin
      n_bad++;
      $display("FAIL %s post_done done=%0b busy=%0b res=%0d want 0/0/%0d",
               tag, bus.done_o, bus.busy_o, bus.result_bo, exp_res);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.start_i = 1'b1; bus.y_bi = 16'd5; bus.a_bi = 8'd1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({bus.result_bo, bus.err_o, bus.busy_o, bus.done_o} !== 19'd0) begin
      n_bad++;
      $display("FAIL reset_state got res=%0d err=%0b busy=%0b done=%0b want 0",
               bus.result_bo, bus.err_o, bus.busy_o, bus.done_o);
    end
    bus.start_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_op("basic", 16'd200, 8'd10);
    run_op("max_legal", 16'd65025, 8'd255);
    run_op("trunc", 16'd100, 8'd7);
    run_op("div_zero", 16'd1234, 8'd0);
    run_op("overflow", 16'd65535, 8'd1);
    run_op("zero_y", 16'd0, 8'd3);
    run_op("q256", 16'd256, 8'd1);
  endtask

  task automatic test_err_clear();
    run_op("err_set", 16'd77, 8'd0);
    bus.y_bi = 16'd49; bus.a_bi = 8'd7; bus.start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start_i = 1'b0;
    n_vec++;
    if (bus.err_o !== 1'b0 || bus.result_bo !== 16'hFFFF || bus.busy_o !== 1'b1) begin
      n_bad++;
      $display("FAIL err_clear got err=%0b res=%0h busy=%0b want 0/ffff/1",
               bus.err_o, bus.result_bo, bus.busy_o);
    end
    repeat (30) @(negedge clk);
    n_vec++;
    if (bus.result_bo !== 16'd49 || bus.err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL err_clear_final got %0d/%0b want 49/0", bus.result_bo, bus.err_o);
    end
  endtask

  task automatic test_held_start();
    int lat;
    bus.y_bi = 16'd100; bus.a_bi = 8'd7; bus.start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.y_bi = 16'd65535; bus.a_bi = 8'd1;
    lat = 0;
    while (!bus.done_o && lat < 40) begin @(negedge clk); lat++; end
    n_vec++;
    if (lat !== 24 || bus.result_bo !== 16'd196) begin
      n_bad++;
      $display("FAIL held_first got lat=%0d res=%0d want 24/196", lat, bus.result_bo);
    end
    @(negedge clk);
    n_vec++;
    if (bus.busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL held_idle_gap got busy=%0b want 0", bus.busy_o);
    end
    @(negedge clk);
    n_vec++;
    if (bus.busy_o !== 1'b1 || bus.result_bo !== 16'd196 || bus.err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL held_second_accept got busy=%0b res=%0d err=%0b want 1/196/0",
               bus.busy_o, bus.result_bo, bus.err_o);
    end
    lat = 0;
    while (!bus.done_o && lat < 40) begin @(negedge clk); lat++; end
    bus.start_i = 1'b0;
    n_vec++;
    if (lat !== 16 || bus.result_bo !== 16'hFFFF || bus.err_o !== 1'b1) begin
      n_bad++;
      $display("FAIL held_second got lat=%0d res=%0h err=%0b want 16/ffff/1",
               lat, bus.result_bo, bus.err_o);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    run_op("pre_reset", 16'd200, 8'd10);
    bus.y_bi = 16'd9000; bus.a_bi = 8'd50; bus.start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.busy_o !== 1'b0 || bus.result_bo !== 16'd0 || bus.err_o !== 1'b0 || bus.done_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid got busy=%0b res=%0d err=%0b done=%0b want 0",
               bus.busy_o, bus.result_bo, bus.err_o, bus.done_o);
    end
    rst = 1'b1;
    saw_done = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done_o || bus.busy_o) saw_done = 1'b1;
    end
    n_vec++;
    if (saw_done) begin
      n_bad++;
      $display("FAIL reset_abort activity after abort got 1 want 0");
    end
    run_op("after_reset", 16'd200, 8'd10);
  endtask

  task automatic test_random();
    logic [7:0]  a;
    logic [15:0] y;
    int          q, r, yy;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) a = 8'd0;
      else a = 8'($urandom_range(1, 255));
      q = $urandom_range(0, 300);
      r = (a == 0) ? $urandom_range(0, 65535) : $urandom_range(0, int'(a) - 1);
      yy = (a == 0) ? r : q * int'(a) + r;
      if (yy > 65535) yy = 65535;
      y = 16'(yy);
      run_op("random", y, a);
    end
  endtask

  initial begin
    bus.start_i = 1'b0; bus.y_bi = '0; bus.a_bi = '0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_err_clear();
    test_held_start();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
